video_timing: RTL and testbench
===============================

// Module: video_timing
// PURPOSE
//  Beam-position and sync timing source for the console video path.
//  - Generates the horizontal (11-bit) and vertical (10-bit) beam counters
//    that every spot generator compares against its position/size inputs.
//  - Generates sync, blanking, a pixel clock-enable and a start-of-frame pulse
//    for the video output stage.
//  - Sits directly upstream of the spot generators; all of them share its
//    horiz/vert outputs.
// PARAMETERS
//  CLK_DIV        4    clk cycles per pixel; legal 1..16
//  H_TOTAL        456  pixels per line; horiz counts 0..H_TOTAL-1
//  H_ACTIVE       368  first horizontally blanked pixel
//  H_SYNC_START   392  first pixel with hsync asserted
//  H_SYNC_LEN     32   hsync width in pixels
//  V_TOTAL        262  lines per frame; vert counts 0..V_TOTAL-1
//  V_ACTIVE       240  first vertically blanked line
//  V_SYNC_START   244  first line with vsync asserted
//  V_SYNC_LEN     3    vsync width in lines
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  run          in   1   1 = counters advance; 0 = freeze all state (pause)
//  ce_pix       out  1   one-clk pulse; marks a pixel step
//  horiz        out  11  horizontal beam position, 0..H_TOTAL-1
//  vert         out  10  vertical beam position (line), 0..V_TOTAL-1
//  hsync        out  1   active-high horizontal sync
//  vsync        out  1   active-high vertical sync
//  hblank       out  1   1 when horiz >= H_ACTIVE
//  vblank       out  1   1 when vert >= V_ACTIVE
//  frame_start  out  1   one-clk pulse when horiz and vert both become 0
// BEHAVIOUR
//  - Reset (async): outputs and internal state take these values.
//      div counter = 0, horiz = 0, vert = 0, all flag outputs = 0,
//      ce_pix = 0, frame_start = 0.
//  - Divider: counts 0..CLK_DIV-1 while run=1, then wraps to 0.
//      ce_pix is registered and is 1 in the clk after the counter reaches
//      CLK_DIV-1. With CLK_DIV=1, ce_pix=1 on every clk.
//  - Pixel step: horiz and vert update in the same clk edge that registers
//    ce_pix=1.
//      horiz == H_TOTAL-1: horiz <= 0 and the line advances.
//      otherwise: horiz <= horiz+1.
//  - Line advance: vert == V_TOTAL-1 gives vert <= 0; otherwise vert+1.
//  - Flags are registered from the next counter values, so they are aligned
//    with horiz/vert and have zero relative latency.
//      hblank = (horiz >= H_ACTIVE)
//      vblank = (vert >= V_ACTIVE)
//      hsync  = (horiz >= H_SYNC_START) && (horiz < H_SYNC_START+H_SYNC_LEN)
//      vsync  = (vert  >= V_SYNC_START) && (vert  < V_SYNC_START+V_SYNC_LEN)
//  - frame_start: 1 for exactly the clk in which the wrap to (0,0) is
//    presented. It is not asserted by reset itself.
//  - run=0: the divider, counters and flags hold. ce_pix and frame_start are
//    0 in the following clk. When run returns to 1, counting resumes from the
//    held divider value; no pixel is skipped or repeated.
//  - Sync ranges: compares are 11-bit unsigned. Sync ranges must lie inside
//    TOTAL, with no wrap across 0; a static check flags violations in
//    simulation.
//  - Reset mid-line: counters return to (0,0) immediately. The first ce_pix
//    after release follows CLK_DIV clks later.
//  - Consumers sample horiz/vert only on ce_pix. Between pulses all outputs
//    are stable.
// TESTING
//  T1 reset: assert reset mid-line (horiz=200, vert=100)
//     -> all outputs 0 asynchronously; first ce_pix 4 clks after release.
//  T2 divider: CLK_DIV=4, run=1 for 40 clks
//     -> 10 ce_pix pulses, spaced exactly 4 clks; horiz steps 0..10.
//  T3 line wrap: horiz 455 at ce_pix -> horiz=0, vert+1.
//     hblank falls at horiz 0 and rises at 368; hsync high on 392..423 only.
//  T4 frame wrap: (455,261) -> (0,0) with frame_start=1 for one clk.
//     vsync high on lines 244..246; vblank on 240..261.
//  T5 pause: run=0 for 17 clks at horiz=100 -> outputs frozen, ce_pix=0.
//     After run=1, horiz=101 appears after the remaining divider count.
//  T6 full frame: count ce_pix between frame_start pulses
//     -> 456*262 = 119472 pulses; CLK_DIV=1 variant gives equal clk count.

Source files
------------

// File: rtl/video_timing.sv
// Beam-position and sync timing source: pixel clock-enable divider, horizontal/vertical
// beam counters, registered sync/blank flags and a start-of-frame pulse.
module video_timing #(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = 456,
  parameter int H_ACTIVE     = 368,
  parameter int H_SYNC_START = 392,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_TOTAL      = 262,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 244,
  parameter int V_SYNC_LEN   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        ce_pix,
  output logic [10:0] horiz,
  output logic [9:0]  vert,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0]      H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]      H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]      HS_BEG   = 11'(H_SYNC_START);
  localparam logic [10:0]      HS_END   = 11'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0]      V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0]      VS_BEG   = 11'(V_SYNC_START);
  localparam logic [10:0]      VS_END   = 11'(V_SYNC_START + V_SYNC_LEN);

  // Geometry sanity: sync windows must sit inside the line/frame without wrapping past 0.
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("video_timing: CLK_DIV %0d outside 1..16", CLK_DIV);
  end
  if (H_TOTAL < 2 || H_TOTAL > 2048 || H_ACTIVE > H_TOTAL) begin : g_bad_h
    $error("video_timing: bad horizontal geometry");
  end
  if (H_SYNC_LEN < 1 || H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_bad_hs
    $error("video_timing: hsync window does not fit inside H_TOTAL");
  end
  if (V_TOTAL < 2 || V_TOTAL > 1024 || V_ACTIVE > V_TOTAL) begin : g_bad_v
    $error("video_timing: bad vertical geometry");
  end
  if (V_SYNC_LEN < 1 || V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_bad_vs
    $error("video_timing: vsync window does not fit inside V_TOTAL");
  end

  logic [DIV_W-1:0] div;
  logic             div_last;
  logic             h_wrap;
  logic             v_wrap;
  logic [10:0]      h_next;
  logic [9:0]       v_next;
  logic [10:0]      v_ext;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    div_last = (div == DIV_LAST);
    h_wrap   = (horiz == H_LAST);
    v_wrap   = (vert == V_LAST);
    h_next   = horiz + 11'd1;
    v_next   = vert;
    if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? '0 : vert + 10'd1;
    end
    v_ext = {1'b0, v_next};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      ce_pix      <= 1'b0;
      frame_start <= 1'b0;
      horiz       <= '0;
      vert        <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
    end else if (run) begin
      div         <= div_last ? '0 : div + DIV_W'(1);
      ce_pix      <= div_last;
      frame_start <= div_last && h_wrap && v_wrap;
      // Flags come from the next counter values so they land in the same edge as horiz/vert.
      if (div_last) begin
        horiz  <= h_next;
        vert   <= v_next;
        hblank <= (h_next >= H_ACT);
        vblank <= (v_ext >= V_ACT);
        hsync  <= (h_next >= HS_BEG) && (h_next < HS_END);
        vsync  <= (v_ext >= VS_BEG) && (v_ext < VS_END);
      end
    end else begin
      ce_pix      <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: a pixel-count arithmetic model compared every cycle,
// plus directed literal checks on a reduced geometry so whole frames fit in a short run.
module tb_video_timing;

  localparam int CLK_DIV = 4;
  localparam int HT  = 20;
  localparam int HA  = 14;
  localparam int HSS = 16;
  localparam int HSL = 2;
  localparam int VT  = 12;
  localparam int VA  = 9;
  localparam int VSS = 10;
  localparam int VSL = 1;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic run1;

  logic        ce_pix, hsync, vsync, hblank, vblank, frame_start;
  logic [10:0] horiz;
  logic [9:0]  vert;
  logic        ce_pix1, hsync1, vsync1, hblank1, vblank1, frame_start1;
  logic [10:0] horiz1;
  logic [9:0]  vert1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  video_timing #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .ce_pix(ce_pix), .horiz(horiz), .vert(vert),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .frame_start(frame_start)
  );

  video_timing #(
    .CLK_DIV(1), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
  ) dut1 (
    .clk(clk), .reset(reset), .run(run1), .ce_pix(ce_pix1), .horiz(horiz1), .vert(vert1),
    .hsync(hsync1), .vsync(vsync1), .hblank(hblank1), .vblank(vblank1), .frame_start(frame_start1)
  );

  logic [26:0] dut_vec, dut1_vec;
  assign dut_vec  = {ce_pix, frame_start, hsync, vsync, hblank, vblank, vert, horiz};
  assign dut1_vec = {ce_pix1, frame_start1, hsync1, vsync1, hblank1, vblank1, vert1, horiz1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count run-enabled clocks since reset; everything else is plain arithmetic on that.
  int m_clks;
  bit m_ce;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clks <= 0;
      m_ce   <= 1'b0;
    end else if (run) begin
      m_clks <= m_clks + 1;
      m_ce   <= ((m_clks + 1) % CLK_DIV) == 0;
    end else begin
      m_ce   <= 1'b0;
    end
  end

  function automatic int m_pix_total();
    return m_clks / CLK_DIV;
  endfunction

  function automatic logic [26:0] model_vec();
    int p, h, v;
    logic hb, vb, hs, vs, fs;
    p  = m_pix_total() % FRAME;
    h  = p % HT;
    v  = p / HT;
    hb = (h >= HA);
    vb = (v >= VA);
    hs = (h >= HSS) && (h < HSS + HSL);
    vs = (v >= VSS) && (v < VSS + VSL);
    fs = m_ce && (p == 0);
    return {m_ce, fs, hs, vs, hb, vb, 10'(v), 11'(h)};
  endfunction

  always @(negedge clk) check("cycle", 32'(dut_vec), 32'(model_vec()));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pix(input int target);
    int k = 0;
    while (m_pix_total() != target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("wait_pix", 32'(m_pix_total()), 32'(target));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    run   = 1'b1;
    run1  = 1'b1;
    tick(2);
    check("rst_vec", 32'(dut_vec), 32'd0);
    #2 reset = 1'b0;

    // Divider: 40 clks give 10 pixel steps, horiz ends at 10.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ce_pix) n++;
    end
    check("t2_pulses", 32'(n), 32'd10);
    check("t2_horiz", 32'(horiz), 32'd10);
    check("t2_ce_last", 32'(ce_pix), 32'd1);
    check("t2_ce1", 32'(ce_pix1), 32'd1);

    // Pause with the divider at 2: frozen for 17 clks, then two clks to the next pixel.
    tick(2);
    run = 1'b0;
    tick(17);
    check("t5_hold_h", 32'(horiz), 32'd10);
    check("t5_hold_ce", 32'(ce_pix), 32'd0);
    run = 1'b1;
    tick(1);
    check("t5_resume1", 32'(horiz), 32'd10);
    tick(1);
    check("t5_resume2", 32'(horiz), 32'd11);
    check("t5_resume_ce", 32'(ce_pix), 32'd1);

    // Line wrap and horizontal flag edges.
    wait_pix(13);
    check("t3_hb13", 32'(hblank), 32'd0);
    wait_pix(14);
    check("t3_hb14", 32'(hblank), 32'd1);
    wait_pix(15);
    check("t3_hs15", 32'(hsync), 32'd0);
    wait_pix(16);
    check("t3_hs16", 32'(hsync), 32'd1);
    wait_pix(17);
    check("t3_hs17", 32'(hsync), 32'd1);
    wait_pix(18);
    check("t3_hs18", 32'(hsync), 32'd0);
    wait_pix(19);
    check("t3_h19", 32'(horiz), 32'd19);
    wait_pix(20);
    check("t3_wrap_h", 32'(horiz), 32'd0);
    check("t3_wrap_v", 32'(vert), 32'd1);
    check("t3_wrap_hb", 32'(hblank), 32'd0);

    // Vertical flags and frame wrap.
    wait_pix(8 * HT);
    check("t4_vb8", 32'(vblank), 32'd0);
    wait_pix(9 * HT);
    check("t4_vb9", 32'(vblank), 32'd1);
    check("t4_vs9", 32'(vsync), 32'd0);
    wait_pix(10 * HT);
    check("t4_vs10", 32'(vsync), 32'd1);
    wait_pix(11 * HT);
    check("t4_vs11", 32'(vsync), 32'd0);
    check("t4_vb11", 32'(vblank), 32'd1);
    wait_pix(FRAME - 1);
    check("t4_last", 32'({vert, horiz}), 32'({10'd11, 11'd19}));
    check("t4_fs_pre", 32'(frame_start), 32'd0);
    wait_pix(FRAME);
    check("t4_origin", 32'({vert, horiz}), 32'd0);
    check("t4_fs", 32'(frame_start), 32'd1);
    check("t4_vb0", 32'(vblank), 32'd0);
    tick(1);
    check("t4_fs_once", 32'(frame_start), 32'd0);

    // Full frame: pixel steps between frame_start pulses.
    n = 0;
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
        if (ce_pix) n++;
      end while (!frame_start && k < 5000);
    end
    check("t6_pulses", 32'(n), 32'(FRAME));

    // CLK_DIV=1 variant: clocks between its frame_start pulses.
    begin
      int k = 0;
      while (!frame_start1 && k < 500) begin
        @(negedge clk);
        k++;
      end
      check("t6_fs1_seen", 32'(frame_start1), 32'd1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!frame_start1 && n < 500);
    end
    check("t6_clks1", 32'(n), 32'(FRAME));

    // Reset mid-line: asynchronous clear, first ce_pix CLK_DIV clks after release.
    wait_pix(3 * FRAME + 3 * HT + 7);
    check("t1_pre", 32'({vert, horiz}), 32'({10'd3, 11'd7}));
    #2 reset = 1'b1;
    #1;
    check("t1_async", 32'(dut_vec), 32'd0);
    check("t1_async1", 32'(dut1_vec), 32'd0);
    tick(2);
    #2 reset = 1'b0;
    for (int e = 1; e <= CLK_DIV; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_ce_e%0d", e), 32'(ce_pix), 32'(e == CLK_DIV));
      if (e == 1) check("t1_ce1", 32'(ce_pix1), 32'd1);
    end
    check("t1_h1", 32'(horiz), 32'd1);
    check("t1_fs", 32'(frame_start), 32'd0);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
